audio_sample_buffer: RTL and testbench
======================================

AUDIO_SAMPLE_BUFFER -- requirements
Module: audio_sample_buffer

Interface
REQ-001 The block SHALL have one clock, clk; reset SHALL be rst, synchronous and active-high.
REQ-002 Parameter DATA_SIZE, default 16, SHALL set the sample width in bits.
REQ-003 Parameter DEPTH, default 16, SHALL set the number of stored samples; it SHALL be a power of two and at least 2.
REQ-004 Parameter ALMOST_FULL_LEVEL, default 12, SHALL set the almost_full threshold; range 1..DEPTH.
REQ-005 Port clk, input, 1, rising-edge clock shared with the upstream I2S receiver output logic.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port in_valid, input, 1, one-cycle pulse marking a completed sample from the I2S receiver.
REQ-008 Port in_data, input, DATA_SIZE, sample word; sampled only when in_valid=1.
REQ-009 Port out_valid, output, 1, high while the buffer holds at least one sample.
REQ-010 Port out_ready, input, 1, consumer accepts out_data this cycle.
REQ-011 Port out_data, output, DATA_SIZE, oldest stored sample; first-word fall-through.
REQ-012 Port level, output, clog2(DEPTH)+1, number of stored samples, 0..DEPTH.
REQ-013 Port almost_full, output, 1, level >= ALMOST_FULL_LEVEL.
REQ-014 Port overflow, output, 1, sticky flag: at least one sample dropped.
REQ-015 Port overflow_clr, input, 1, one-cycle request to clear overflow.

Function
REQ-016 A read SHALL occur on a rising edge when out_valid=1 and out_ready=1; out_ready while out_valid=0 SHALL have no effect.
REQ-017 A write SHALL occur when in_valid=1 and either level<DEPTH or a read occurs in the same cycle.
REQ-018 When in_valid=1, level=DEPTH and no read occurs, the sample SHALL be dropped (newest discarded), contents unchanged.
REQ-019 Write and read pointers SHALL be clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-020 level SHALL update on the same edge as the access: +1 write only, -1 read only, unchanged for both or neither.
REQ-021 Latency: a sample written at edge N SHALL be visible on out_data with out_valid=1 after edge N when the buffer was empty; no same-cycle bypass from in_data to out_data.
REQ-022 Simultaneous read and write while level=0 is impossible (out_valid=0); only the write SHALL occur.
REQ-023 out_valid SHALL equal (level != 0); out_data SHALL equal the entry at the read pointer and SHALL remain stable while out_valid=1 and no read occurs.
REQ-024 Samples SHALL leave in exactly the order accepted, with no duplication or loss other than per REQ-018.
REQ-025 overflow SHALL be set on the edge following a dropped sample; it SHALL clear on the edge following overflow_clr=1.
REQ-026 When a drop and overflow_clr coincide, overflow SHALL be set (set wins).
REQ-027 almost_full SHALL be derived from the registered level with no additional latency.

Reset
REQ-028 On rst=1 at a rising edge, pointers and level SHALL become 0, out_valid 0, almost_full 0, overflow 0.
REQ-029 Storage contents SHALL NOT be cleared; out_data is don't-care while out_valid=0.
REQ-030 rst SHALL take priority over any concurrent in_valid, read or overflow_clr; samples held mid-operation SHALL be discarded.

Verification
REQ-031 Single sample: reset, in_valid pulse with in_data=0x1234, out_ready=0 -> next cycle out_valid=1, out_data=0x1234, level=1; assert out_ready one cycle -> level=0, out_valid=0.
REQ-032 Fill and overflow (defaults): write 17 samples 0x0001..0x0011, no reads -> level=16, almost_full=1 from level 12, overflow=1 after 17th; drain -> 0x0001..0x0010 in order, 0x0011 absent.
REQ-033 Full with concurrent access: level=16, in_valid and out_ready same cycle with in_data=0xBEEF -> level stays 16, overflow unchanged, 0xBEEF read out last.
REQ-034 Wrap-around: 40 write/read pairs at random gaps with level kept between 1 and 15 -> output sequence equals input sequence, pointers wrap without loss.
REQ-035 Overflow clear: overflow=1, pulse overflow_clr -> overflow=0 next cycle; repeat with overflow_clr coinciding with a drop -> overflow stays 1.
REQ-036 Reset mid-operation: level=5, assert rst for one cycle with in_valid=1 -> level=0, out_valid=0, overflow=0, almost_full=0; next write 0x00AA is first sample out.

Source files
------------

// File: rtl/audio_sample_buffer.sv
// Sample FIFO between an I2S receiver and its consumer: first-word fall-through
// output, drop-newest on overflow with a sticky overflow flag.
module audio_sample_buffer #(
  parameter int DATA_SIZE         = 16,
  parameter int DEPTH             = 16,
  parameter int ALMOST_FULL_LEVEL = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_SIZE-1:0]     in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_SIZE-1:0]     out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic                     overflow,
  input  logic                     overflow_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_LV = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LV    = LW'(ALMOST_FULL_LEVEL);

  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 overflow_q, overflow_d;
  logic                 rd_en, wr_en, drop;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    drop       = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;

    rd_en = (level_q != '0) && out_ready;
    // A read in the same cycle frees a slot, so a full buffer still accepts.
    wr_en = in_valid && ((level_q != DEPTH_LV) || rd_en);
    drop  = in_valid && !wr_en;

    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);

    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (drop)              overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage is deliberately not reset; level gates validity, and leaving
  // the array reset-free lets it map onto RAM instead of flops.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_ptr_q] <= in_data;
  end

  assign out_valid   = (level_q != '0);
  assign out_data    = mem_q[rd_ptr_q];
  assign level       = level_q;
  assign almost_full = (level_q >= AF_LV);
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_audio_sample_buffer.sv
// Directed bench for audio_sample_buffer: hand-checked vectors plus a reference
// queue that predicts read order, level and flags each cycle.
module tb_audio_sample_buffer;

  localparam int AFL   = 12;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [4:0]  level;
  logic        almost_full;
  logic        overflow;
  logic        overflow_clr;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [15:0] model[$];
  logic        exp_ov = 1'b0;
  logic [15:0] last_rd = '0;

  audio_sample_buffer #(
    .DATA_SIZE(16), .DEPTH(DEPTH), .ALMOST_FULL_LEVEL(AFL)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .almost_full(almost_full), .overflow(overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock with the given inputs; the queue predicts the effect.
  task automatic do_cycle(input logic iv, input logic [15:0] d, input logic rdy,
                          input logic clr);
    int  sz0;
    logic rd, wr;
    sz0          = model.size();
    in_valid     = iv;
    in_data      = d;
    out_ready    = rdy;
    overflow_clr = clr;
    rd = rdy && (sz0 > 0);
    wr = iv && ((sz0 < DEPTH) || rd);
    if (rd) begin
      check("rd_data", out_data, model[0]);
      last_rd = model.pop_front();
    end
    if (wr) model.push_back(d);
    if (iv && !wr)  exp_ov = 1'b1;
    else if (clr)   exp_ov = 1'b0;
    step();
    in_valid = 1'b0; out_ready = 1'b0; overflow_clr = 1'b0;
    check("level", level, model.size());
    check("out_valid", out_valid, model.size() != 0);
    check("almost_full", almost_full, model.size() >= AFL);
    check("overflow", overflow, exp_ov);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && model.size() > 0; i++) do_cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; overflow_clr = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_level", level, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_almost_full", almost_full, 0);
    check("rst_overflow", overflow, 0);

    // Single sample, fall-through latency of one edge
    do_cycle(1'b1, 16'h1234, 1'b0, 1'b0);
    check("single_data", out_data, 16'h1234);
    check("single_level", level, 1);
    do_cycle(1'b0, '0, 1'b1, 1'b0);
    check("single_empty", out_valid, 0);

    // Fill with 17 samples; the 17th is dropped
    for (int i = 1; i <= 17; i++) begin
      do_cycle(1'b1, 16'(i), 1'b0, 1'b0);
      if (i == 11) check("af_at_11", almost_full, 0);
      if (i == 12) check("af_at_12", almost_full, 1);
    end
    check("full_level", level, 16);
    check("full_overflow", overflow, 1);
    check("full_head", out_data, 16'h0001);
    step();
    check("head_stable", out_data, 16'h0001);

    // Full with concurrent read and write
    do_cycle(1'b1, 16'hBEEF, 1'b1, 1'b0);
    check("conc_level", level, 16);
    check("conc_overflow", overflow, 1);
    check("conc_next", out_data, 16'h0002);
    drain();
    check("drain_last", last_rd, 16'hBEEF);

    // Overflow clear, then drop coinciding with clear
    do_cycle(1'b0, '0, 1'b0, 1'b1);
    check("ovclr", overflow, 0);
    for (int i = 0; i < 16; i++) do_cycle(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
    check("refill_ov", overflow, 0);
    do_cycle(1'b1, 16'h0999, 1'b0, 1'b1);
    check("set_wins", overflow, 1);
    drain();
    check("refill_last", last_rd, 16'h010F);

    // Wrap-around with random gaps, level kept within 1..15
    do_cycle(1'b1, 16'h2000, 1'b0, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      int mode;
      int gap;
      gap  = $urandom_range(0, 2);
      mode = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) do_cycle(1'b0, '0, 1'b0, 1'b0);
      if (mode == 2 && model.size() > 1)        do_cycle(1'b0, '0, 1'b1, 1'b0);
      else if (mode == 0 && model.size() < 15)  do_cycle(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0);
      else                                      do_cycle(1'b1, 16'h2000 + 16'(i), 1'b1, 1'b0);
    end
    drain();

    // Reset mid-operation with in_valid asserted; overflow is still set here
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 16'h0300 + 16'(i), 1'b0, 1'b0);
    check("pre_rst_level", level, 5);
    check("pre_rst_ov", overflow, 1);
    rst = 1'b1; in_valid = 1'b1; in_data = 16'h0055; out_ready = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    model.delete();
    exp_ov = 1'b0;
    check("mid_rst_level", level, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ov", overflow, 0);
    check("mid_rst_af", almost_full, 0);
    do_cycle(1'b1, 16'h00AA, 1'b0, 1'b0);
    check("post_rst_first", out_data, 16'h00AA);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
